// File: rtl/mem_region_decoder.sv
// Registered virtual-to-physical region decoder with valid/ready output stage and sticky fault capture.
// Optional write protection of read-only windows is enabled by defining MEMDEC_WPROT_EN.
module mem_region_decoder #(
  parameter int                           NUM_REGIONS  = 2,
  parameter int                           PADDR_W      = 13,
  parameter logic [NUM_REGIONS*32-1:0]    REGION_BASE  = {32'h7FFFEFFC, 32'h10010000},
  parameter logic [NUM_REGIONS*32-1:0]    REGION_LIMIT = {32'h7FFFFFFC, 32'h10011000},
  parameter logic [NUM_REGIONS*32-1:0]    REGION_PBASE = {32'h00000400, 32'h00000000},
  parameter logic [NUM_REGIONS-1:0]       REGION_RO    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_vaddr,
  input  logic [1:0]             req_size,
  input  logic                   req_write,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PADDR_W-1:0]     out_paddr,
  output logic [NUM_REGIONS-1:0] out_bank,
  output logic                   out_inv,
  output logic                   out_misalign,
  output logic                   out_wprot,
  output logic                   fault_pend,
  output logic [31:0]            fault_vaddr,
  input  logic                   fault_clr
);

  logic                   hit_found;
  logic [NUM_REGIONS-1:0] hit_bank;
  logic [PADDR_W-1:0]     hit_off;
  logic                   dec_misalign;
  logic                   dec_wprot;
  logic                   dec_fault;
  logic                   accept;

  logic                   out_valid_q,    out_valid_d;
  logic [PADDR_W-1:0]     out_paddr_q,    out_paddr_d;
  logic [NUM_REGIONS-1:0] out_bank_q,     out_bank_d;
  logic                   out_inv_q,      out_inv_d;
  logic                   out_misalign_q, out_misalign_d;
  logic                   out_wprot_q,    out_wprot_d;
  logic                   fault_pend_q,   fault_pend_d;
  logic [31:0]            fault_vaddr_q,  fault_vaddr_d;

  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;

  // Translation only needs the low PADDR_W bits: the truncated sum is identical mod 2^PADDR_W.
  always_comb begin
    hit_found = 1'b0;
    hit_bank  = '0;
    hit_off   = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_found &&
          req_vaddr >= REGION_BASE[i*32 +: 32] &&
          req_vaddr <  REGION_LIMIT[i*32 +: 32]) begin
        hit_found   = 1'b1;
        hit_bank[i] = 1'b1;
        hit_off     = req_vaddr[PADDR_W-1:0] - REGION_BASE[i*32 +: PADDR_W]
                      + REGION_PBASE[i*32 +: PADDR_W];
      end
    end
  end

  always_comb begin
    dec_misalign = 1'b0;
    case (req_size)
      2'd0:    dec_misalign = 1'b0;
      2'd1:    dec_misalign = req_vaddr[0];
      2'd2:    dec_misalign = |req_vaddr[1:0];
      default: dec_misalign = 1'b1;
    endcase
  end

`ifdef MEMDEC_WPROT_EN
  assign dec_wprot = req_write && |(hit_bank & REGION_RO);
`else
  logic unused_write;
  assign unused_write = req_write;
  assign dec_wprot    = 1'b0;
`endif

  assign dec_fault = !hit_found || dec_misalign || dec_wprot;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_paddr_d    = out_paddr_q;
    out_bank_d     = out_bank_q;
    out_inv_d      = out_inv_q;
    out_misalign_d = out_misalign_q;
    out_wprot_d    = out_wprot_q;
    fault_pend_d   = fault_pend_q;
    fault_vaddr_d  = fault_vaddr_q;

    if (accept) begin
      out_valid_d    = 1'b1;
      out_paddr_d    = dec_fault ? '0 : hit_off;
      out_bank_d     = dec_fault ? '0 : hit_bank;
      out_inv_d      = !hit_found;
      out_misalign_d = dec_misalign;
      out_wprot_d    = dec_wprot;
    end else if (out_ready) begin
      out_valid_d    = 1'b0;
    end

    // A clear in the same cycle as a new fault lets the new fault take the capture slot.
    if (accept && dec_fault) begin
      fault_pend_d = 1'b1;
      if (!fault_pend_q || fault_clr) begin
        fault_vaddr_d = req_vaddr;
      end
    end else if (fault_clr) begin
      fault_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_paddr_q    <= '0;
      out_bank_q     <= '0;
      out_inv_q      <= 1'b0;
      out_misalign_q <= 1'b0;
      out_wprot_q    <= 1'b0;
      fault_pend_q   <= 1'b0;
      fault_vaddr_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_paddr_q    <= out_paddr_d;
      out_bank_q     <= out_bank_d;
      out_inv_q      <= out_inv_d;
      out_misalign_q <= out_misalign_d;
      out_wprot_q    <= out_wprot_d;
      fault_pend_q   <= fault_pend_d;
      fault_vaddr_q  <= fault_vaddr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_paddr    = out_paddr_q;
  assign out_bank     = out_bank_q;
  assign out_inv      = out_inv_q;
  assign out_misalign = out_misalign_q;
  assign out_wprot    = out_wprot_q;
  assign fault_pend   = fault_pend_q;
  assign fault_vaddr  = fault_vaddr_q;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Bench for mem_region_decoder: directed literal checks plus randomized traffic against a behavioural model.
module tb_mem_region_decoder;

`ifdef MEMDEC_WPROT_EN
  localparam logic [1:0] TB_RO = 2'b01;
`else
  localparam logic [1:0] TB_RO = 2'b00;
`endif

  localparam logic [31:0] M_BASE  [2] = '{32'h10010000, 32'h7FFFEFFC};
  localparam logic [31:0] M_LIMIT [2] = '{32'h10011000, 32'h7FFFFFFC};
  localparam logic [31:0] M_PBASE [2] = '{32'h00000000, 32'h00000400};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vaddr = '0;
  logic [1:0]  req_size = '0;
  logic        req_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_paddr;
  logic [1:0]  out_bank;
  logic        out_inv;
  logic        out_misalign;
  logic        out_wprot;
  logic        fault_pend;
  logic [31:0] fault_vaddr;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_region_decoder #(
    .NUM_REGIONS (2),
    .PADDR_W     (13),
    .REGION_BASE ({32'h7FFFEFFC, 32'h10010000}),
    .REGION_LIMIT({32'h7FFFFFFC, 32'h10011000}),
    .REGION_PBASE({32'h00000400, 32'h00000000}),
    .REGION_RO   (TB_RO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_size(req_size), .req_write(req_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_paddr(out_paddr),
    .out_bank(out_bank), .out_inv(out_inv), .out_misalign(out_misalign),
    .out_wprot(out_wprot), .fault_pend(fault_pend), .fault_vaddr(fault_vaddr),
    .fault_clr(fault_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: what the registered outputs must hold.
  logic        m_valid, m_inv, m_mis, m_wp, m_pend;
  logic [31:0] m_paddr, m_fva;
  logic [1:0]  m_bank;

  always @(posedge clk or posedge rst) begin
    logic        acc, inv, mis, wp, flt;
    logic [31:0] pa;
    logic [1:0]  bank;
    int          win;
    if (rst) begin
      m_valid = 0; m_inv = 0; m_mis = 0; m_wp = 0; m_pend = 0;
      m_paddr = 0; m_fva = 0; m_bank = 0;
    end else begin
      acc = req_valid && (!m_valid || out_ready);
      win = -1;
      for (int i = 1; i >= 0; i--)
        if (req_vaddr >= M_BASE[i] && req_vaddr < M_LIMIT[i]) win = i;
      inv  = (win < 0);
      mis  = (req_size == 3) || (req_size == 2 && req_vaddr % 4 != 0) ||
             (req_size == 1 && req_vaddr % 2 != 0);
      wp   = 0;
`ifdef MEMDEC_WPROT_EN
      wp   = !inv && req_write && TB_RO[win];
`endif
      flt  = inv || mis || wp;
      pa   = inv ? 0 : (req_vaddr - M_BASE[win] + M_PBASE[win]) % 8192;
      bank = inv ? 2'b00 : 2'(1 << win);
      if (acc) begin
        m_valid = 1; m_inv = inv; m_mis = mis; m_wp = wp;
        m_paddr = flt ? 0 : pa;
        m_bank  = flt ? 2'b00 : bank;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (acc && flt) begin
        if (!m_pend || fault_clr) m_fva = req_vaddr;
        m_pend = 1;
      end else if (fault_clr) begin
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(!m_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("fault_pend", 32'(fault_pend), 32'(m_pend));
      chk("fault_vaddr", fault_vaddr, m_fva);
      if (m_valid) begin
        chk("out_paddr", 32'(out_paddr), m_paddr);
        chk("out_bank", 32'(out_bank), 32'(m_bank));
        chk("out_inv", 32'(out_inv), 32'(m_inv));
        chk("out_misalign", 32'(out_misalign), 32'(m_mis));
        chk("out_wprot", 32'(out_wprot), 32'(m_wp));
      end
    end
  end

  // Present one request; returns at posedge+2 after it was taken.
  task automatic send(input logic [31:0] va, input logic [1:0] sz, input logic wr);
    req_vaddr = va; req_size = sz; req_write = wr; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h10010000 + 32'($urandom_range(0, 32'h1003));
      1: return 32'h7FFFEFFC + 32'($urandom_range(0, 32'h1003));
      2: return 32'h10010000 - 32'($urandom_range(0, 4));
      3: begin
        logic [31:0] pts [4] = '{32'h10011000, 32'h7FFFFFFC, 32'h7FFFEFFC, 32'h10010000};
        return pts[$urandom_range(0, 3)];
      end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [12:0] held_pa;
    idle(2);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fault_pend", 32'(fault_pend), 32'd0);
    rst = 1'b0;
    idle(1);

    send(32'h10010010, 2'd2, 1'b0);
    chk("d1_valid", 32'(out_valid), 32'd1);
    chk("d1_bank", 32'(out_bank), 32'h1);
    chk("d1_paddr", 32'(out_paddr), 32'h0010);
    chk("d1_flags", 32'({out_inv, out_misalign, out_wprot}), 32'd0);

    send(32'h7FFFEFFC, 2'd2, 1'b0);
    chk("d2_bank", 32'(out_bank), 32'h2);
    chk("d2_paddr", 32'(out_paddr), 32'h0400);

    send(32'h7FFFFFFC, 2'd2, 1'b0);
    chk("d3_inv", 32'(out_inv), 32'd1);
    chk("d3_paddr", 32'(out_paddr), 32'd0);
    chk("d3_bank", 32'(out_bank), 32'd0);
    fault_clr = 1'b1; idle(1); fault_clr = 1'b0;
    chk("d3_clr", 32'(fault_pend), 32'd0);

    out_ready = 1'b0;
    send(32'h10010020, 2'd2, 1'b0);
    held_pa = out_paddr;
    chk("bp_first_paddr", 32'(held_pa), 32'h0020);
    req_vaddr = 32'h10010040; req_size = 2'd2; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      idle(1);
      chk("bp_paddr_stable", 32'(out_paddr), 32'(held_pa));
    end
    out_ready = 1'b1;
    idle(1);
    req_valid = 1'b0;
    chk("bp_next_paddr", 32'(out_paddr), 32'h0040);

    send(32'h10010002, 2'd2, 1'b0);
    chk("f1_mis", 32'(out_misalign), 32'd1);
    chk("f1_pend", 32'(fault_pend), 32'd1);
    chk("f1_fva", fault_vaddr, 32'h10010002);
    send(32'h00000000, 2'd2, 1'b0);
    chk("f2_inv", 32'(out_inv), 32'd1);
    chk("f2_fva_kept", fault_vaddr, 32'h10010002);
    fault_clr = 1'b1;
    send(32'h20000000, 2'd0, 1'b0);
    chk("f3_pend", 32'(fault_pend), 32'd1);
    chk("f3_fva", fault_vaddr, 32'h20000000);
    fault_clr = 1'b1; idle(1); fault_clr = 1'b0;

    send(32'h10010004, 2'd2, 1'b1);
`ifdef MEMDEC_WPROT_EN
    chk("wp_store_wprot", 32'(out_wprot), 32'd1);
    chk("wp_store_bank", 32'(out_bank), 32'd0);
`else
    chk("wp_store_wprot", 32'(out_wprot), 32'd0);
    chk("wp_store_bank", 32'(out_bank), 32'h1);
`endif
    send(32'h10010004, 2'd2, 1'b0);
    chk("wp_load_bank", 32'(out_bank), 32'h1);
    chk("wp_load_wprot", 32'(out_wprot), 32'd0);

    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_vaddr = rand_addr();
      req_size  = 2'($urandom_range(0, 3));
      req_write = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      idle(1);
    end
    req_valid = 1'b0; fault_clr = 1'b0; out_ready = 1'b1;
    idle(2);

    fault_clr = 1'b1; idle(1); fault_clr = 1'b0;
    out_ready = 1'b0;
    send(32'h00000004, 2'd2, 1'b0);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    chk("rst_pre_pend", 32'(fault_pend), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_pend", 32'(fault_pend), 32'd0);
    chk("rst_async_fva", fault_vaddr, 32'd0);
    chk("rst_async_flags", 32'({out_inv, out_misalign, out_wprot}), 32'd0);
    chk("rst_async_paddr_bank", 32'({out_paddr, out_bank}), 32'd0);
    idle(2);
    out_ready = 1'b1;
    rst = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
